// File: rtl/expr_pkg.sv
// Shared types and constants for the expression arbiter and its checker core.
package expr_pkg;

  // Checker core states; encodings are fixed so they stay stable across the slice.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    RIGHT = 2'b01,
    ERROR = 2'b10,
    SIGN  = 2'b11
  } chk_state_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    REPORT
  } ctl_state_t;

  localparam logic [7:0] TERM_DEF = 8'h3B;  // ';'
  localparam logic [7:0] CH_PLUS  = 8'h2B;  // '+'
  localparam logic [7:0] CH_STAR  = 8'h2A;  // '*'
  localparam logic [7:0] CH_0     = 8'h30;  // '0'
  localparam logic [7:0] CH_9     = 8'h39;  // '9'

endpackage

// File: rtl/expr_check_core.sv
// Four-state single-digit infix checker: digit (op digit)* is accepted.
module expr_check_core
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       feed,
  input  logic [7:0] data,
  output logic       accept
);

  chk_state_t state;
  chk_state_t state_n;
  logic       is_digit;
  logic       is_op;

  // Next-state rule; only a fed byte moves the checker, ERROR is sticky.
  always_comb begin
    is_digit = (data >= CH_0) && (data <= CH_9);
    is_op    = (data == CH_PLUS) || (data == CH_STAR);
    state_n  = state;
    if (feed) begin
      case (state)
        EMPTY, SIGN: state_n = is_digit ? RIGHT : ERROR;
        RIGHT:       state_n = is_op ? SIGN : ERROR;
        default:     state_n = ERROR;
      endcase
    end
  end

  // State register; reset and start both return the checker to EMPTY.
  always_ff @(posedge clk) begin
    if (clr || start) state <= EMPTY;
    else              state <= state_n;
  end

  assign accept = (state == RIGHT);

endmodule

// File: rtl/expr_arbiter.sv
// Round-robin framing arbiter sharing one expression checker between two byte streams.
module expr_arbiter
  import expr_pkg::*;
#(
  parameter logic [7:0]  TERM  = TERM_DEF,
  parameter int unsigned LEN_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_ok,
  output logic             res_src,
  output logic [LEN_W-1:0] res_len,
  input  logic             res_ready
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  ctl_state_t       state;
  ctl_state_t       state_n;
  logic             src;
  logic             grant_n;
  logic             last_src;
  logic [LEN_W-1:0] len;
  logic             ovf;
  logic             start;
  logic             feed;
  logic             term_hs;
  logic             hs;
  logic [7:0]       cur;
  logic             accept;

  expr_check_core u_core (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .feed   (feed),
    .data   (cur),
    .accept (accept)
  );

  // Controller: grant, stream routing and result presentation.
  always_comb begin
    state_n    = state;
    grant_n    = src;
    start      = 1'b0;
    feed       = 1'b0;
    term_hs    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    res_valid  = 1'b0;
    hs         = src ? req1_valid : req0_valid;
    cur        = src ? req1_data : req0_data;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          start   = 1'b1;
          grant_n = (req0_valid && req1_valid) ? ~last_src : req1_valid;
          state_n = STREAM;
        end
      end
      STREAM: begin
        req0_ready = ~src;
        req1_ready = src;
        if (hs) begin
          if (cur == TERM) begin
            term_hs = 1'b1;
            state_n = REPORT;
          end else begin
            feed = 1'b1;
          end
        end
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered controller state, length/overflow tracking and captured result.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      src      <= 1'b0;
      last_src <= 1'b1;
      len      <= '0;
      ovf      <= 1'b0;
      res_ok   <= 1'b0;
      res_src  <= 1'b0;
      res_len  <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        src <= grant_n;
        len <= '0;
        ovf <= 1'b0;
      end
      if (feed) begin
        if (len == LEN_MAX) ovf <= 1'b1;
        else                len <= len + 1'b1;
      end
      if (term_hs) begin
        res_ok  <= accept & ~ovf;
        res_src <= src;
        res_len <= len;
      end
      if (state == REPORT && res_ready) last_src <= src;
    end
  end

endmodule
